// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS ALU with iterative mul/div into HI/LO; ALU_MC_FAST_MUL_EN selects a single-cycle multiplier
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic                   overflow_o,
  output logic                   div_zero_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [W-1:0] acc, acc_d, q, q_d, mb, a_r, ma_c, mb_c, sum, dif, simple, quo, rem, hi_f, lo_f;
  logic [W:0] sum_m, rs, df;
  logic [2*W-1:0] prod, prod_s, pfs;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic div_r, neg_q, neg_r, dz_r, ovf_c, is_md, is_mul, sgn, neg_c, last, fast;
  assign is_md  = alu_operation_i[3] & (alu_operation_i[2] ^ alu_operation_i[1]);
  assign is_mul = alu_operation_i[3:1] == 3'b101;
  assign sgn    = alu_operation_i[0];
  assign ma_c   = (sgn & a_i[W-1]) ? -a_i : a_i;
  assign mb_c   = (sgn & b_i[W-1]) ? -b_i : b_i;
  assign neg_c  = sgn & (a_i[W-1] ^ b_i[W-1]);
  assign last   = cnt == SHAMT_WIDTH'(W - 1);
  assign busy_o = state == RUN;
  assign done_o = state == DONE;
  assign sum    = a_i + b_i;
  assign dif    = a_i - b_i;
`ifdef ALU_MC_FAST_MUL_EN
  logic [2*W-1:0] pf;
  assign pf   = {{W{1'b0}}, ma_c} * {{W{1'b0}}, mb_c};
  assign pfs  = neg_c ? -pf : pf;
  assign fast = is_mul;
`else
  assign pfs  = '0;
  assign fast = 1'b0;
`endif
  // acc:q is the product shift register for multiply and remainder:quotient for divide
  assign sum_m  = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
  assign rs     = {acc, q[W-1]};
  assign df     = rs - {1'b0, mb};
  assign acc_d  = div_r ? (df[W] ? rs[W-1:0] : df[W-1:0]) : sum_m[W:1];
  assign q_d    = div_r ? {q[W-2:0], ~df[W]} : {sum_m[0], q[W-1:1]};
  assign prod   = {acc_d, q_d};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -q_d : q_d;
  assign rem    = neg_r ? -acc_d : acc_d;
  assign hi_f   = div_r ? (dz_r ? a_r : rem) : prod_s[2*W-1:W];
  assign lo_f   = div_r ? (dz_r ? '1 : quo) : prod_s[W-1:0];
  // single-cycle results and add/sub signed overflow
  always_comb begin
    simple = '0;
    ovf_c  = 1'b0;
    case (alu_operation_i)
      4'b0011: begin
        simple = sum;
        ovf_c  = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      4'b0101: begin
        simple = dif;
        ovf_c  = (a_i[W-1] != b_i[W-1]) && (dif[W-1] != a_i[W-1]);
      end
      4'b0000: simple = {b_i[W/2-1:0], {(W/2){1'b0}}};
      4'b0001: simple = a_i | b_i;
      4'b0110: simple = a_i & b_i;
      4'b0111: simple = ~(a_i | b_i);
      4'b0010: simple = b_i << shamt_i;
      4'b0100: simple = b_i >> shamt_i;
      4'b1001: simple = $signed(b_i) >>> shamt_i;
      4'b1000: simple = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      default: simple = '0;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_d;
  // next state: DONE accepts a new start just like IDLE
  always_comb begin
    state_d = IDLE;
    if (state == RUN) state_d = last ? DONE : RUN;
    else if (start_i) state_d = (is_md && !fast) ? RUN : DONE;
  end
  // operand latch, iteration step and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      {acc, q, mb, a_r, cnt, div_r, neg_q, neg_r, dz_r} <= '0;
      {alu_data_o, zero_o, overflow_o, div_zero_o, hi_o, lo_o} <= '0;
    end else if (state == RUN) begin
      acc <= acc_d;
      q   <= q_d;
      cnt <= cnt + SHAMT_WIDTH'(1);
      if (last) begin
        hi_o       <= hi_f;
        lo_o       <= lo_f;
        alu_data_o <= lo_f;
        zero_o     <= lo_f == '0;
        overflow_o <= 1'b0;
        if (div_r) div_zero_o <= dz_r;
      end
    end else if (start_i && is_md && !fast) begin
      acc   <= '0;
      q     <= ma_c;
      mb    <= mb_c;
      a_r   <= a_i;
      cnt   <= '0;
      div_r <= alu_operation_i[2];
      neg_q <= neg_c;
      neg_r <= sgn & a_i[W-1];
      dz_r  <= b_i == '0;
    end else if (start_i && fast) begin
      hi_o       <= pfs[2*W-1:W];
      lo_o       <= pfs[W-1:0];
      alu_data_o <= pfs[W-1:0];
      zero_o     <= pfs[W-1:0] == '0;
      overflow_o <= 1'b0;
    end else if (start_i) begin
      alu_data_o <= simple;
      zero_o     <= simple == '0;
      overflow_o <= ovf_c;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed bench for alu_mc at W=32 and W=16 against a spec-level model
module tb_alu_mc;
`ifdef ALU_MC_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic st[2];
  logic [3:0] op[2];
  logic [31:0] a[2], b[2];
  logic [4:0] sh[2];
  logic [31:0] r32, h32, l32;
  logic [15:0] r16, h16, l16;
  logic z32, v32, d32, bz32, dn32, z16, v16, d16, bz16, dn16;
  logic [31:0] res[2], hi[2], lo[2];
  logic zero[2], ovf[2], dz[2], busy[2], done[2];
  logic [31:0] e_res[2], e_hi[2], e_lo[2], p_hi[2], p_lo[2];
  logic e_zero[2], e_ovf[2], e_dz[2], e_done[2], p_dz[2], p_div[2];
  int left[2];
  int n_chk = 0, n_fail = 0;

  alu_mc #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start_i(st[0]), .alu_operation_i(op[0]), .a_i(a[0]), .b_i(b[0]),
    .shamt_i(sh[0]), .alu_data_o(r32), .zero_o(z32), .overflow_o(v32), .div_zero_o(d32),
    .hi_o(h32), .lo_o(l32), .busy_o(bz32), .done_o(dn32));
  alu_mc #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start_i(st[1]), .alu_operation_i(op[1]), .a_i(a[1][15:0]), .b_i(b[1][15:0]),
    .shamt_i(sh[1][3:0]), .alu_data_o(r16), .zero_o(z16), .overflow_o(v16), .div_zero_o(d16),
    .hi_o(h16), .lo_o(l16), .busy_o(bz16), .done_o(dn16));

  always_comb begin
    res[0] = r32; res[1] = 32'(r16);
    hi[0] = h32; hi[1] = 32'(h16);
    lo[0] = l32; lo[1] = 32'(l16);
    zero[0] = z32; zero[1] = z16;
    ovf[0] = v32; ovf[1] = v16;
    dz[0] = d32; dz[1] = d16;
    busy[0] = bz32; busy[1] = bz16;
    done[0] = dn32; done[1] = dn16;
  end

  function automatic int wid(input int k);
    return (k != 0) ? 16 : 32;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // what a w-bit ALU must produce for one operation, from plain integer arithmetic
  function automatic void calc(input int w, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] s, output logic [31:0] r, output logic [31:0] h,
                               output logic [31:0] l, output logic v, output logic md, output logic dv);
    longint m, sx, sy, t, mx, mn;
    logic [63:0] ux, uy, p;
    int n;
    m = (longint'(1) << w) - 1;
    ux = 64'(x) & 64'(m);
    uy = 64'(y) & 64'(m);
    sx = longint'(ux);
    sy = longint'(uy);
    if (ux[w-1]) sx -= longint'(1) << w;
    if (uy[w-1]) sy -= longint'(1) << w;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    n = int'(s) & (w - 1);
    r = 0; h = 0; l = 0; v = 0; md = 0; dv = 0;
    case (o)
      4'd3: begin t = sx + sy; v = t > mx || t < mn; r = 32'(t & m); end
      4'd5: begin t = sx - sy; v = t > mx || t < mn; r = 32'(t & m); end
      4'd0: r = 32'((uy << (w / 2)) & 64'(m));
      4'd1: r = 32'(ux | uy);
      4'd6: r = 32'(ux & uy);
      4'd7: r = 32'(~(ux | uy) & 64'(m));
      4'd2: r = 32'((uy << n) & 64'(m));
      4'd4: r = 32'(uy >> n);
      4'd9: r = 32'((sy >>> n) & m);
      4'd8: r = 32'(sx < sy);
      4'd10: begin md = 1; p = ux * uy; h = 32'((p >> w) & 64'(m)); l = 32'(p & 64'(m)); end
      4'd11: begin md = 1; p = 64'(sx * sy); h = 32'((p >> w) & 64'(m)); l = 32'(p & 64'(m)); end
      4'd12: begin
        md = 1;
        if (uy == 0) begin l = 32'(m); h = 32'(ux); dv = 1; end
        else begin l = 32'(ux / uy); h = 32'(ux % uy); end
      end
      4'd13: begin
        md = 1;
        if (sy == 0) begin l = 32'(m); h = 32'(ux); dv = 1; end
        else begin l = 32'((sx / sy) & m); h = 32'((sx % sy) & m); end
      end
      default: r = 0;
    endcase
    if (md) r = l;
  endfunction

  // expected outputs: simple ops finish next cycle, iterative ops are busy for w cycles first
  always @(posedge clk) begin
    logic [31:0] r, h, l;
    logic v, md, dv, mul;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        e_res[k] = 0; e_hi[k] = 0; e_lo[k] = 0;
        e_zero[k] = 0; e_ovf[k] = 0; e_dz[k] = 0; e_done[k] = 0; left[k] = 0;
      end else if (left[k] > 0) begin
        left[k]--;
        e_done[k] = left[k] == 0;
        if (e_done[k]) begin
          e_hi[k] = p_hi[k]; e_lo[k] = p_lo[k]; e_res[k] = p_lo[k];
          e_zero[k] = p_lo[k] == 0; e_ovf[k] = 0;
          if (p_div[k]) e_dz[k] = p_dz[k];
        end
      end else begin
        e_done[k] = 0;
        if (st[k]) begin
          calc(wid(k), op[k], a[k], b[k], sh[k], r, h, l, v, md, dv);
          mul = op[k] == 4'd10 || op[k] == 4'd11;
          if (md && !(FAST && mul)) begin
            left[k] = wid(k);
            p_hi[k] = h; p_lo[k] = l; p_dz[k] = dv; p_div[k] = !mul;
          end else begin
            e_done[k] = 1;
            e_res[k] = md ? l : r;
            e_zero[k] = (md ? l : r) == 0;
            e_ovf[k] = md ? 1'b0 : v;
            if (md) begin e_hi[k] = h; e_lo[k] = l; end
          end
        end
      end
    end
  end

  // cycle-by-cycle comparison of every output against the model
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("w%0d busy", wid(k)), 32'(busy[k]), 32'(left[k] > 0));
      chk($sformatf("w%0d done", wid(k)), 32'(done[k]), 32'(e_done[k]));
      chk($sformatf("w%0d alu_data", wid(k)), res[k], e_res[k]);
      chk($sformatf("w%0d zero", wid(k)), 32'(zero[k]), 32'(e_zero[k]));
      chk($sformatf("w%0d overflow", wid(k)), 32'(ovf[k]), 32'(e_ovf[k]));
      chk($sformatf("w%0d hi", wid(k)), hi[k], e_hi[k]);
      chk($sformatf("w%0d lo", wid(k)), lo[k], e_lo[k]);
      chk($sformatf("w%0d div_zero", wid(k)), 32'(dz[k]), 32'(e_dz[k]));
    end
  end

  task automatic launch(input int k, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s, input bit now);
    if (!now) @(negedge clk);
    op[k] = o; a[k] = x; b[k] = y; sh[k] = s; st[k] = 1'b1;
  endtask

  // drops start, scrambles operands while waiting, returns cycles from launch to done
  task automatic finish_op(input int k, output int cyc);
    @(negedge clk);
    st[k] = 1'b0;
    cyc = 1;
    while (!done[k] && cyc < 100) begin
      a[k] = $urandom; b[k] = $urandom; sh[k] = 5'($urandom);
      @(negedge clk);
      cyc++;
    end
    chk("done reached", 32'(done[k]), 32'd1);
  endtask

  task automatic run(input int k, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] s, input bit now, output int cyc);
    launch(k, o, x, y, s, now);
    finish_op(k, cyc);
  endtask

  initial begin
    int c;
    logic [3:0] ops[7] = '{4'd1, 4'd6, 4'd7, 4'd2, 4'd4, 4'd8, 4'd15};
    for (int k = 0; k < 2; k++) begin st[k] = 0; op[k] = 0; a[k] = 0; b[k] = 0; sh[k] = 0; end
    repeat (2) @(negedge clk);
    chk("reset alu_data", res[0], 32'h0);
    chk("reset hi", hi[0], 32'h0);
    chk("reset busy", 32'(busy[0]), 32'h0);
    chk("reset done", 32'(done[0]), 32'h0);
    reset = 1'b0;
    run(0, 4'd3, 32'h7FFFFFFF, 32'h1, 0, 0, c);
    chk("add result", res[0], 32'h80000000);
    chk("add overflow", 32'(ovf[0]), 32'h1);
    chk("add zero", 32'(zero[0]), 32'h0);
    chk("add latency", 32'(c), 32'd1);
    run(0, 4'd5, 32'd5, 32'd5, 0, 0, c);
    chk("sub result", res[0], 32'h0);
    chk("sub zero", 32'(zero[0]), 32'h1);
    run(0, 4'd9, 32'h0, 32'h80000000, 5'd4, 0, c);
    chk("sra result", res[0], 32'hF8000000);
    run(0, 4'd0, 32'h0, 32'h1234, 0, 0, c);
    chk("lui result", res[0], 32'h12340000);
    run(0, 4'd8, 32'hFFFFFFFF, 32'h1, 0, 0, c);
    chk("slt result", res[0], 32'h1);
    foreach (ops[i]) run(0, ops[i], 32'hF0F0_1234 + 32'(i), 32'h8765_00FF, 5'(7 * i + 3), 0, c);
    run(0, 4'd11, 32'hFFFFFFFD, 32'd7, 0, 0, c);
    chk("mult hi", hi[0], 32'hFFFFFFFF);
    chk("mult lo", lo[0], 32'hFFFFFFEB);
    chk("mult alu_data", res[0], 32'hFFFFFFEB);
    chk("mult latency", 32'(c), FAST ? 32'd1 : 32'd33);
    run(0, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, c);
    chk("multu hi", hi[0], 32'hFFFFFFFE);
    chk("multu lo", lo[0], 32'h1);
    run(0, 4'd13, 32'hFFFFFFF9, 32'd2, 0, 0, c);
    chk("div lo", lo[0], 32'hFFFFFFFD);
    chk("div hi", hi[0], 32'hFFFFFFFF);
    run(0, 4'd13, 32'h80000000, 32'hFFFFFFFF, 0, 0, c);
    chk("div min lo", lo[0], 32'h80000000);
    chk("div min hi", hi[0], 32'h0);
    chk("div min flag", 32'(dz[0]), 32'h0);
    run(0, 4'd12, 32'd9, 32'd0, 0, 0, c);
    chk("divu0 lo", lo[0], 32'hFFFFFFFF);
    chk("divu0 hi", hi[0], 32'd9);
    chk("divu0 flag", 32'(dz[0]), 32'h1);
    chk("divu0 latency", 32'(c), 32'd33);
    run(0, 4'd3, 32'd1, 32'd1, 0, 0, c);
    chk("add keeps hi", hi[0], 32'd9);
    chk("add keeps flag", 32'(dz[0]), 32'h1);
    run(0, 4'd10, 32'd6, 32'd7, 0, 0, c);
    run(0, 4'd13, 32'd100, 32'hFFFFFFF9, 0, 0, c);
    launch(0, 4'd12, 32'd100, 32'd7, 0, 0);
    @(negedge clk);
    st[0] = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (cyc == 4) begin op[0] = 4'd3; a[0] = 32'd1; b[0] = 32'd1; st[0] = 1'b1; end
      else st[0] = 1'b0;
      @(negedge clk);
    end
    st[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort alu_data", res[0], 32'h0);
    chk("abort hi", hi[0], 32'h0);
    chk("abort lo", lo[0], 32'h0);
    chk("abort busy", 32'(busy[0]), 32'h0);
    chk("abort done", 32'(done[0]), 32'h0);
    run(0, 4'd3, 32'd2, 32'd3, 0, 0, c);
    chk("add after abort", res[0], 32'd5);
    chk("add after abort latency", 32'(c), 32'd1);
    run(0, 4'd14, 32'd2, 32'd3, 0, 0, c);
    chk("op14 result", res[0], 32'h0);
    run(1, 4'd10, 32'hFFFF, 32'hFFFF, 0, 0, c);
    chk("w16 multu hi", hi[1], 32'h0000FFFE);
    chk("w16 multu lo", lo[1], 32'h00000001);
    chk("w16 multu latency", 32'(c), FAST ? 32'd1 : 32'd17);
    run(1, 4'd13, 32'hFF9C, 32'd7, 0, 1, c);
    chk("w16 b2b div lo", lo[1], 32'h0000FFF2);
    chk("w16 b2b div hi", hi[1], 32'h0000FFFE);
    chk("w16 div latency", 32'(c), 32'd17);
    run(1, 4'd3, 32'h7FFF, 32'h1, 0, 1, c);
    chk("w16 add overflow", 32'(ovf[1]), 32'h1);
    run(1, 4'd9, 32'h0, 32'h8000, 5'd3, 0, c);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the MIPS datapath; next generation of the single-cycle ALU.
- Adds configurable width, AND/NOR/SLT/SRA, and signed/unsigned iterative multiply/divide into HI/LO registers.
- Uses a start/busy/done handshake so the control unit can stall the pipeline during long operations.
- Registered outputs; sits in EX stage between the operand muxes and the EX/MEM register.

Parameters:
- DATA_WIDTH, 32, operand/result width; even, >=8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), derived localparam; not overridable.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  launch operation; sampled only when busy_o=0.
- alu_operation_i  input  4  opcode, see Behaviour.
- a_i  input  DATA_WIDTH  operand A (rs).
- b_i  input  DATA_WIDTH  operand B (rt/imm).
- shamt_i  input  SHAMT_WIDTH  shift amount.
- alu_data_o  output  DATA_WIDTH  registered result.
- zero_o  output  1  alu_data_o==0, registered with it.
- overflow_o  output  1  signed overflow of ADD/SUB; 0 for all other ops.
- div_zero_o  output  1  last DIV/DIVU had b_i==0.
- hi_o  output  DATA_WIDTH  HI register.
- lo_o  output  DATA_WIDTH  LO register.
- busy_o  output  1  multi-cycle op in progress.
- done_o  output  1  one-cycle pulse: result valid.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal counter/accumulators 0. Reset mid-operation aborts it; no done_o; HI/LO cleared.
- Opcodes (4 bits):
  - 0011 ADD: A+B. 0101 SUB: A-B.
  - 0000 LUI: {B[W/2-1:0], W/2 zeros}.
  - 0001 OR. 0110 AND. 0111 NOR.
  - 0010 SLL: B<<shamt. 0100 SRL: B>>shamt (logical). 1001 SRA: B>>>shamt (arithmetic).
  - 1000 SLT: signed A<B gives 1, else 0.
  - 1010 MULTU, 1011 MULT, 1100 DIVU, 1101 DIV.
  - 1110, 1111: result 0, done after 1 cycle.
- FSM states:
  - IDLE: on start_i, a single-cycle op registers its result, goes to DONE. A mul/div op latches operands and goes to RUN with count=0.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; after DATA_WIDTH steps goes to DONE.
  - DONE: done_o=1 for exactly this cycle, busy_o=0, then IDLE. start_i in DONE is accepted as if in IDLE (back-to-back issue).
- busy_o=1 in RUN and in the launch cycle's following cycles until DONE. start_i while busy_o=1 is ignored.
- Latency from start_i: 1 cycle for simple ops; DATA_WIDTH+1 cycles for mul/div.
- Operand latching: a_i/b_i/shamt_i/op sampled only at launch; later changes have no effect.
- Multiply: full 2W-bit product, HI=upper W bits, LO=lower W bits.
  - MULT: sign-magnitude; magnitudes multiplied, product negated when signs differ.
- Divide: LO=quotient, HI=remainder.
  - DIV truncates toward zero; remainder takes the sign of the dividend.
  - MIN/-1: LO=MIN, HI=0, no flag.
  - Divide by zero: LO=all ones, HI=a_i, div_zero_o=1. Still takes the full latency.
- alu_data_o = LO for mul/div ops; zero_o follows it.
- HI/LO/div_zero_o change only when a mul/div completes; simple ops leave them untouched.
- overflow_o updated on every completed op. alu_data_o/zero_o hold their value between completions.

Optional Feature:
- Macro: ALU_MC_FAST_MUL_EN.
- Defined: MULT/MULTU use a combinational W x W multiplier and complete with single-cycle latency (DONE next cycle, never enter RUN). Divide is unchanged.
- Undefined: iterative multiplier as above; no '*' operator is synthesised.

Test Plan:
- Reset then ADD a=0x7FFFFFFF b=1 (W=32) -> next cycle done_o=1, alu_data_o=0x80000000, overflow_o=1, zero_o=0.
- SUB a=5 b=5 -> alu_data_o=0, zero_o=1. SRA b=0x80000000 shamt=4 -> 0xF8000000. LUI b=0x1234 -> 0x12340000.
- MULT a=-3 b=7 -> busy_o high 32 cycles, done_o at cycle 33: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. With ALU_MC_FAST_MUL_EN: done_o at cycle 1.
- DIV a=-7 b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU a=9 b=0 -> lo_o=0xFFFFFFFF, hi_o=9, div_zero_o=1.
- Start DIVU, pulse start_i with ADD mid-RUN (ignored), then assert reset at cycle 10 -> no done_o, all outputs 0. Next ADD 2+3 -> 5 after 1 cycle.
- Param W=16: MULTU 0xFFFF*0xFFFF -> hi_o=0xFFFE, lo_o=0x0001, done_o at cycle 17. Back-to-back start_i in DONE cycle accepted.
